// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 control path: FSM states,
// instruction classes, opcode match table and ALUOp codes.
package legv8_ctrl_pkg;

    localparam int OPC_W    = 11;
    localparam int NUM_PAT  = 5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_CBZ  = 3'd3,
        CLS_B    = 3'd4,
        CLS_R    = 3'd5
    } class_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    // Match table in priority order: a lower index wins when several match.
    // A pattern hits when (opcode & mask) == value.
    localparam logic [OPC_W-1:0] OPC_VAL [NUM_PAT] = '{
        11'b11111000010,    // LDUR
        11'b11111000000,    // STUR
        11'b10110100000,    // CBZ  10110100xxx
        11'b00010100000,    // B    000101xxxxx
        11'b10001010000     // R    1xx0101x000
    };

    localparam logic [OPC_W-1:0] OPC_MASK [NUM_PAT] = '{
        11'b11111111111,
        11'b11111111111,
        11'b11111111000,
        11'b11111100000,
        11'b10011110111
    };

    localparam class_t OPC_CLASS [NUM_PAT] = '{
        CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_R
    };

    function automatic logic opcode_match(input logic [OPC_W-1:0] opcode,
                                          input logic [OPC_W-1:0] value,
                                          input logic [OPC_W-1:0] mask);
        return (opcode & mask) == value;
    endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational opcode-to-class decoder; unmatched opcodes give CLS_NONE.
// Shared by the single-cycle and multi-cycle control paths.
module instr_class_decoder
    import legv8_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output class_t           instr_class
);

    logic [NUM_PAT-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PAT; gi++) begin : g_match
            assign hit[gi] = opcode_match(opcode, OPC_VAL[gi], OPC_MASK[gi]);
        end
    endgenerate

    // Walk from lowest priority upward so the first table entry has the last word.
    always_comb begin
        instr_class = CLS_NONE;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                instr_class = OPC_CLASS[i];
            end
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory-ready
// handshake, a sticky illegal-opcode halt and a retired-instruction counter.
module multicycle_control_fsm
    import legv8_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_src,
    output logic               ir_write,
    output logic               reg2loc,
    output logic               alusrc,
    output logic               memtoreg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_fault,
    output logic [CNT_W-1:0]   retired,
    output logic [2:0]         state
);

    state_t           state_reg, state_next;
    class_t           class_reg, class_next;
    class_t           dec_class;
    logic             fault_reg, fault_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;
    logic [1:0]       alu_code;

    instr_class_decoder u_decoder (
        .opcode      (opcode),
        .instr_class (dec_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            class_reg   <= CLS_NONE;
            fault_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            class_reg <= class_next;
            fault_reg <= fault_next;
            if (retire) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        class_next = class_reg;
        fault_next = fault_reg;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        alusrc     = 1'b0;
        memtoreg   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_code   = ALU_ADD;

        case (state_reg)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end

            // Only state that looks at the opcode; B finishes here.
            S_DECODE: begin
                class_next = dec_class;
                case (dec_class)
                    CLS_B: begin
                        pc_write   = 1'b1;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    CLS_NONE: begin
                        fault_next = 1'b1;
                        state_next = S_HALT;
                    end
                    default: state_next = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (class_reg)
                    CLS_LDUR: begin
                        alusrc     = 1'b1;
                        state_next = S_MEM;
                    end
                    CLS_STUR: begin
                        alusrc     = 1'b1;
                        reg2loc    = 1'b1;
                        state_next = S_MEM;
                    end
                    CLS_R: begin
                        alu_code   = ALU_RTYPE;
                        state_next = S_WB;
                    end
                    CLS_CBZ: begin
                        reg2loc    = 1'b1;
                        alu_code   = ALU_PASSB;
                        pc_src     = 1'b1;
                        pc_write   = zero;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        fault_next = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end

            // Address path stays stable for the whole memory wait.
            S_MEM: begin
                alusrc = 1'b1;
                case (class_reg)
                    CLS_LDUR: begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            state_next = S_WB;
                        end
                    end
                    CLS_STUR: begin
                        reg2loc   = 1'b1;
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    default: begin
                        fault_next = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end

            S_WB: begin
                reg_write  = 1'b1;
                memtoreg   = (class_reg == CLS_LDUR);
                alu_code   = (class_reg == CLS_R) ? ALU_RTYPE : ALU_ADD;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: state_next = S_FETCH;
        endcase
    end

    assign alu_op      = ALUOP_W'(alu_code);
    assign instr_fault = fault_reg;
    assign retired     = retired_reg;
    assign state       = state_reg;

endmodule
